// File: rtl/nor_chain_pulse_tester.sv
// Parametrised NOR2 inverter chain with an on-chip pulse sequencer, tap synchroniser,
// received-pulse counter and launch-to-arrival latency measurement.

module NOR2_X1 (
    input  logic A1,
    input  logic A2,
    output logic ZN
);
    assign ZN = ~(A1 | A2);
endmodule

module nor_chain_pulse_tester #(
    parameter int STAGES  = 6,
    parameter int TAP_W   = 3,
    parameter int PW_W    = 8,
    parameter int CNT_W   = 16,
    parameter int OBS_CYC = 4
) (
    input  logic             myclk,
    input  logic             myrst,
    input  logic             mystart,
    input  logic [PW_W-1:0]  mypw,
    input  logic [PW_W-1:0]  mygap,
    input  logic [CNT_W-1:0] mynum,
    input  logic [TAP_W-1:0] mytap,
    output logic             myin,
    output logic             myout,
    output logic             mybusy,
    output logic             mydone,
    output logic [CNT_W-1:0] mysent,
    output logic [CNT_W-1:0] myrecv,
    output logic [CNT_W-1:0] mylat
);

    localparam int OW = (OBS_CYC > 1) ? $clog2(OBS_CYC) : 1;
    localparam int CW = (PW_W > OW) ? PW_W : OW;
    localparam int TN = 1 << TAP_W;

    typedef enum logic [2:0] {IDLE, SETTLE, HIGH, LOW, OBS, DONE} state_t;

    state_t             state, nstate;
    logic [CW-1:0]      cnt;
    logic [PW_W-1:0]    pw_last, gap_last;
    logic [CNT_W-1:0]   num_r;
    logic [TAP_W-1:0]   tap_r;
    logic [CNT_W-1:0]   latcnt;
    logic               armed;
    logic               blocknet;
    logic [STAGES-1:0]  stg;
    logic [TN-1:0]      tapvec;
    logic               s1, s2, s2d;
    logic               launch, det;

    // The chain under test: every side input shares the block net.
    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            logic a1, zn;
            if (k == 0) begin : g_a
                assign a1 = myin;
            end else begin : g_a
                assign a1 = g_stage[k-1].zn;
            end
            NOR2_X1 u_nor (.A1(a1), .A2(blocknet), .ZN(zn));
            assign stg[k] = zn;
        end
    endgenerate

    assign myout  = stg[STAGES-1];
    assign tapvec = TN'(stg);

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (mystart) nstate = SETTLE;
            SETTLE:  if (cnt == CW'(OBS_CYC - 1)) nstate = (num_r != '0) ? HIGH : DONE;
            HIGH:    if (cnt == CW'(pw_last)) nstate = LOW;
            LOW:     if (cnt == CW'(gap_last)) nstate = OBS;
            OBS:     if (cnt == CW'(OBS_CYC - 1)) nstate = (mysent < num_r) ? HIGH : DONE;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Active level at a tap is 1 for odd stages, so tap_r[0] doubles as the active level.
    assign launch = (nstate == HIGH) && (state != HIGH);
    assign det    = ((state == HIGH) || (state == LOW) || (state == OBS)) &&
                    (s2 == tap_r[0]) && (s2d != tap_r[0]);

    always_ff @(posedge myclk) begin
        if (myrst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nstate;
            if ((nstate != state) || (state == IDLE))
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge myclk) begin
        if (myrst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            s2d <= 1'b0;
        end else begin
            s1  <= tapvec[tap_r];
            s2  <= s1;
            s2d <= s2;
        end
    end

    always_ff @(posedge myclk) begin
        if (myrst) begin
            myin     <= 1'b0;
            blocknet <= 1'b1;
            mybusy   <= 1'b0;
            mydone   <= 1'b0;
            mysent   <= '0;
            myrecv   <= '0;
            mylat    <= '0;
            latcnt   <= '0;
            armed    <= 1'b0;
            pw_last  <= '0;
            gap_last <= '0;
            num_r    <= '0;
            tap_r    <= '0;
        end else begin
            myin     <= (nstate == HIGH);
            blocknet <= (nstate == IDLE) || (nstate == DONE);
            mybusy   <= (nstate != IDLE) && (nstate != DONE);
            mydone   <= (nstate == DONE);
            if ((state == IDLE) && mystart) begin
                pw_last  <= (mypw == '0) ? '0 : mypw - PW_W'(1);
                gap_last <= (mygap == '0) ? '0 : mygap - PW_W'(1);
                num_r    <= mynum;
                tap_r    <= (int'(mytap) >= STAGES) ? TAP_W'(STAGES - 1) : mytap;
                mysent   <= '0;
                myrecv   <= '0;
                mylat    <= '0;
                armed    <= 1'b0;
            end else begin
                if (latcnt != '1)
                    latcnt <= latcnt + CNT_W'(1);
                if (det) begin
                    if (myrecv != '1)
                        myrecv <= myrecv + CNT_W'(1);
                    if (armed) begin
                        mylat <= latcnt;
                        armed <= 1'b0;
                    end
                end
                // A fresh launch re-arms latency capture even if an old edge lands this cycle.
                if (launch) begin
                    mysent <= mysent + CNT_W'(1);
                    latcnt <= '0;
                    armed  <= 1'b1;
                end
            end
        end
    end

endmodule
